// File: rtl/pipelined_adder_pkg.sv
// Shared constants and elaboration helpers for the sliced add/subtract pipeline.
package pipelined_adder_pkg;

    localparam logic ADD_OP = 1'b0;
    localparam logic SUB_OP = 1'b1;

    function automatic int ceil_div(input int num, input int den);
        return (den < 1) ? 1 : (num + den - 1) / den;
    endfunction

    function automatic int clog2_int(input int val);
        int r;
        r = 0;
        while ((1 << r) < val) r++;
        return r;
    endfunction

    function automatic int slice_lo(input int idx, input int chunk);
        return idx * chunk;
    endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// One CHUNK-bit slice of the adder: adds its slice with the incoming carry and
// registers carry, valid, the operands and the partially built result.
module pipelined_adder_stage
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic             in_carry,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_s,
    output logic             out_valid,
    output logic             out_carry,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_s
);

    localparam int LO = slice_lo(IDX, CHUNK);

    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] s_next;

    always_comb begin
        sum    = {1'b0, in_a[LO +: CHUNK]} + {1'b0, in_b[LO +: CHUNK]}
               + {{CHUNK{1'b0}}, in_carry};
        s_next = in_s;
        s_next[LO +: CHUNK] = sum[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_carry <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_s     <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_carry <= sum[CHUNK];
            out_a     <= in_a;
            out_b     <= in_b;
            out_s     <= s_next;
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract pipelined one CHUNK-bit slice per stage, with
// valid/ready flow control where every stage advances or holds together.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int STAGES = ceil_div(WIDTH, CHUNK);

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("pipelined_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    logic                          advance;
    logic [STAGES:0]               vld_pipe;
    logic [STAGES:0]               c_pipe;
    logic [STAGES:0][WIDTH-1:0]    a_pipe;
    logic [STAGES:0][WIDTH-1:0]    b_pipe;
    logic [STAGES:0][WIDTH-1:0]    s_pipe;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Subtraction is a + ~b + ~borrow, so both inversions happen before stage 0.
    assign vld_pipe[0] = in_valid;
    assign c_pipe[0]   = (sub == SUB_OP) ? ~c_in : c_in;
    assign a_pipe[0]   = a;
    assign b_pipe[0]   = (sub == SUB_OP) ? ~b : b;
    assign s_pipe[0]   = '0;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            pipelined_adder_stage #(
                .WIDTH (WIDTH),
                .CHUNK (CHUNK),
                .IDX   (k)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (advance),
                .in_valid  (vld_pipe[k]),
                .in_carry  (c_pipe[k]),
                .in_a      (a_pipe[k]),
                .in_b      (b_pipe[k]),
                .in_s      (s_pipe[k]),
                .out_valid (vld_pipe[k+1]),
                .out_carry (c_pipe[k+1]),
                .out_a     (a_pipe[k+1]),
                .out_b     (b_pipe[k+1]),
                .out_s     (s_pipe[k+1])
            );
        end
    endgenerate

    assign out_valid = vld_pipe[STAGES];
    assign s         = s_pipe[STAGES];
    assign c_out     = c_pipe[STAGES];
    // Operand MSBs ride along with the beat so overflow needs no extra state.
    assign ovf       = (a_pipe[STAGES][WIDTH-1] == b_pipe[STAGES][WIDTH-1])
                    && (s_pipe[STAGES][WIDTH-1] != a_pipe[STAGES][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed cases on an 8/4 instance, a corner case plus
// random traffic on a 32/8 instance, both scored against an arithmetic model.
module tb_pipelined_adder;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        ovf;
        int          acc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 8-bit, 2-stage instance
    logic       in_valid8 = 0, in_ready8, c_in8 = 0, sub8 = 0, out_valid8, out_ready8 = 1, c_out8, ovf8;
    logic [7:0] a8 = 0, b8 = 0, s8;
    // 32-bit, 4-stage instance
    logic        in_valid32 = 0, in_ready32, c_in32 = 0, sub32 = 0, out_valid32, out_ready32 = 1, c_out32, ovf32;
    logic [31:0] a32 = 0, b32 = 0, s32;

    pipelined_adder #(.WIDTH(8), .CHUNK(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .c_in(c_in8), .sub(sub8), .out_valid(out_valid8),
        .out_ready(out_ready8), .s(s8), .c_out(c_out8), .ovf(ovf8));

    pipelined_adder #(.WIDTH(32), .CHUNK(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .c_in(c_in32), .sub(sub32), .out_valid(out_valid32),
        .out_ready(out_ready32), .s(s32), .c_out(c_out32), .ovf(ovf32));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Plain integer arithmetic: unsigned result for s/c_out, signed range test for ovf.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sb);
        exp_t   e;
        longint ua, ub, r, sa, sr, full, half;
        full = longint'(1) << w;
        half = longint'(1) << (w - 1);
        ua = longint'(a);
        ub = longint'(b);
        r  = sb ? ua - ub - longint'(cin) : ua + ub + longint'(cin);
        e.s   = 32'(((r % full) + full) % full);
        e.c   = sb ? (r >= 0) : (r >= full);
        sa    = (ua >= half) ? ua - full : ua;
        sr    = (ub >= half) ? ub - full : ub;
        sr    = sb ? sa - sr - longint'(cin) : sa + sr + longint'(cin);
        e.ovf = (sr < -half) || (sr > half - 1);
        e.acc = 0;
        e.lat = 0;
        return e;
    endfunction

    exp_t q8[$], pend8[$], q32[$], pend32[$];
    bit   lat8 = 1, lat32 = 1, held8 = 0, held32 = 0;
    logic [7:0]  held_s8;
    logic [31:0] held_s32;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q8.delete();
            held8 = 0;
        end else begin
            if (held8) chk("hold_s8", s8, held_s8);
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) chk("spurious8", 1, 0);
                else begin
                    e = q8.pop_front();
                    chk("s8", s8, e.s);
                    chk("c_out8", c_out8, e.c);
                    chk("ovf8", ovf8, e.ovf);
                    if (e.lat) chk("latency8", cyc - e.acc, 2);
                end
            end
            if (in_valid8 && in_ready8) begin
                e = (pend8.size() != 0) ? pend8.pop_front() : model(8, a8, b8, c_in8, sub8);
                e.acc = cyc;
                e.lat = lat8;
                q8.push_back(e);
            end
            held8   = out_valid8 && !out_ready8;
            held_s8 = s8;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q32.delete();
            held32 = 0;
        end else begin
            if (held32) chk("hold_s32", s32, held_s32);
            if (out_valid32 && out_ready32) begin
                if (q32.size() == 0) chk("spurious32", 1, 0);
                else begin
                    e = q32.pop_front();
                    chk("s32", s32, e.s);
                    chk("c_out32", c_out32, e.c);
                    chk("ovf32", ovf32, e.ovf);
                    if (e.lat) chk("latency32", cyc - e.acc, 4);
                end
            end
            if (in_valid32 && in_ready32) begin
                e = (pend32.size() != 0) ? pend32.pop_front() : model(32, a32, b32, c_in32, sub32);
                e.acc = cyc;
                e.lat = lat32;
                q32.push_back(e);
            end
            held32   = out_valid32 && !out_ready32;
            held_s32 = s32;
        end
    end

    task automatic expect8(input logic [7:0] s, input logic c, input logic o);
        exp_t e;
        e.s = 32'(s); e.c = c; e.ovf = o; e.acc = 0; e.lat = 0;
        pend8.push_back(e);
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb);
        bit acc;
        int n;
        n = 0;
        a8 = a; b8 = b; c_in8 = ci; sub8 = sb; in_valid8 = 1;
        do begin
            @(negedge clk);
            acc = in_ready8;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send8_timeout", 0, 1);
    endtask

    task automatic drain(input bit wide);
        int n;
        n = 0;
        while (((wide ? q32.size() : q8.size()) != 0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk(wide ? "drain32" : "drain8", wide ? q32.size() : q8.size(), 0);
    endtask

    initial begin
        bit hold, acc;
        int nacc, stall;
        exp_t e;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid8", out_valid8, 0);
        chk("rst_s8", s8, 0);
        chk("rst_c_out8", c_out8, 0);
        chk("rst_ovf8", ovf8, 0);
        chk("rst_out_valid32", out_valid32, 0);
        chk("rst_s32", s32, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        // back-to-back adds, incl. wrap-around carry
        expect8(8'h01, 0, 0); expect8(8'h00, 1, 0); expect8(8'h1F, 1, 0);
        send8(8'h00, 8'h00, 1, 0);
        send8(8'h80, 8'h7F, 1, 0);
        send8(8'h7F, 8'hA0, 0, 0);
        in_valid8 = 0;
        drain(0);

        // subtraction and signed overflow
        expect8(8'hFE, 0, 0); expect8(8'h7F, 1, 1);
        expect8(8'h80, 0, 1); expect8(8'h00, 1, 0);
        send8(8'h05, 8'h07, 0, 1);
        send8(8'h80, 8'h01, 0, 1);
        send8(8'h7F, 8'h01, 0, 0);
        send8(8'hFF, 8'h01, 0, 0);
        in_valid8 = 0;
        drain(0);

        // 6-beat stream with a 3-cycle output stall
        lat8 = 0;
        nacc = 0;
        for (int t = 0; t < 40 && nacc < 6; t++) begin
            stall = (t >= 3 && t < 6);
            out_ready8 = !stall;
            a8 = 8'(8'h11 * (nacc + 1)); b8 = 8'(8'h2C + nacc); c_in8 = nacc[0]; sub8 = nacc[1];
            in_valid8 = 1;
            @(negedge clk);
            if (stall) chk("stall_in_ready8", in_ready8, 0);
            if (in_valid8 && in_ready8) nacc++;
            @(posedge clk); #1;
        end
        in_valid8 = 0;
        out_ready8 = 1;
        chk("stream_accepted8", nacc, 6);
        drain(0);

        // reset with two beats in flight
        out_ready8 = 0;
        send8(8'h21, 8'h43, 0, 0);
        send8(8'h65, 8'h10, 1, 1);
        in_valid8 = 0;
        chk("inflight_valid8", out_valid8, 1);
        rst_n = 0;
        #1;
        chk("async_rst_valid8", out_valid8, 0);
        chk("async_rst_s8", s8, 0);
        @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1;
        out_ready8 = 1;
        lat8 = 1;
        @(posedge clk); #1;
        expect8(8'h46, 0, 0);
        send8(8'h12, 8'h34, 0, 0);
        in_valid8 = 0;
        drain(0);

        // 32-bit: carry ripples across every slice
        begin
            e.s = 32'h0; e.c = 1; e.ovf = 0; e.acc = 0; e.lat = 0;
            pend32.push_back(e);
        end
        a32 = 32'hFFFF_FFFF; b32 = 32'h0; c_in32 = 1; sub32 = 0; in_valid32 = 1;
        @(posedge clk); #1;
        in_valid32 = 0;
        drain(1);

        // random traffic with random valid/ready
        lat32 = 0;
        hold = 0;
        nacc = 0;
        for (int t = 0; t < 20000 && nacc < 1000; t++) begin
            if (!hold) begin
                in_valid32 = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 7))
                    0:       a32 = 32'hFFFF_FFFF;
                    1:       a32 = 32'h8000_0000;
                    default: a32 = $urandom;
                endcase
                case ($urandom_range(0, 7))
                    0:       b32 = 32'h7FFF_FFFF;
                    1:       b32 = 32'h0;
                    default: b32 = $urandom;
                endcase
                c_in32 = 1'($urandom_range(0, 1));
                sub32  = 1'($urandom_range(0, 1));
            end
            out_ready32 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid32 && in_ready32;
            if (acc) nacc++;
            hold = in_valid32 && !acc;
            @(posedge clk); #1;
        end
        in_valid32 = 0;
        out_ready32 = 1;
        chk("random_accepted32", nacc, 1000);
        drain(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
